memory_access: RTL

Memory stage of the eCPU pipeline, sitting directly between execute and writeback. It issues load/store requests to the data-memory port with a request/acknowledge handshake and formats byte lanes and store data. It sign- or zero-extends load data and registers the result, ALU result, destination register and instruction into the writeback stage. It stalls upstream for the duration of every memory access.

---
 rtl/ecpu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/memory_access.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ecpu_pkg.sv
// Shared eCPU definitions: opcodes, funct3 codes and the memory-stage state type.
package ecpu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, BUSY} mem_state_t;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated store data, and load
// extraction with sign or zero extension. Purely combinational.
module lsu_align
  import ecpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_raw,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0]        byte_lane;
  logic [XLEN-1:0]        half_lane;
  logic signed [7:0]      byte_s;
  logic signed [15:0]     half_s;
  logic signed [XLEN-1:0] byte_sx;
  logic signed [XLEN-1:0] half_sx;

  // Halfword lane uses addr[1] only, so a stray addr[0] is dropped here.
  assign byte_lane = load_raw >> {offset, 3'b000};
  assign half_lane = load_raw >> {offset[1], 4'b0000};
  assign byte_s    = signed'(byte_lane[7:0]);
  assign half_s    = signed'(half_lane[15:0]);
  assign byte_sx   = byte_s;
  assign half_sx   = half_s;

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_raw;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {{(XLEN-8){1'b0}}, byte_lane[7:0]} : unsigned'(byte_sx);
      end
      2'b01: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {{(XLEN-16){1'b0}}, half_lane[15:0]} : unsigned'(half_sx);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// eCPU memory stage: request/ack data-memory access, stall control and the
// writeback register. Optional misaligned-access trap: MEM_MISALIGN_CHECK_EN.
module memory_access
  import ecpu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ILEN           = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  input  logic [ILEN-1:0]           instr_i,
  input  logic [XLEN-1:0]           alu_result_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      reg_write_i,
  output logic                      stall_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [XLEN-1:0]           dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [XLEN-1:0]           dmem_wdata_o,
  input  logic [XLEN-1:0]           dmem_rdata_i,
  input  logic                      dmem_ack_i,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                      misalign_o,
`endif
  output logic                      valid_o,
  output logic [ILEN-1:0]           instr_o,
  output logic [XLEN-1:0]           alu_result_o,
  output logic [XLEN-1:0]           mem_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      reg_write_o
);

  mem_state_t      state, state_next;
  logic [2:0]      funct3;
  logic            is_load, is_store, mem_op;
  logic            misalign, mem_go, ack_done, wb_load;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c, load_c;

  assign funct3   = instr_i[14:12];
  assign is_load  = instr_i[6:0] == OPC_LOAD;
  assign is_store = instr_i[6:0] == OPC_STORE;
  assign mem_op   = is_mem_op(instr_i[6:0]);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op && (((funct3[1:0] == 2'b01) && alu_result_i[0]) ||
                               (funct3[1] && (alu_result_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // A trapped misaligned op never reaches memory and so never stalls.
  assign mem_go   = valid_i && mem_op && !misalign;
  assign ack_done = (state == BUSY) && dmem_ack_i;
  assign stall_o  = mem_go && !ack_done;
  assign wb_load  = ((state == IDLE) && valid_i && !mem_go) || ack_done;

  lsu_align #(.XLEN(XLEN)) u_lsu_align (
    .funct3     (funct3),
    .offset     (alu_result_i[1:0]),
    .store_data (rs2_data_i),
    .load_raw   (dmem_rdata_i),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_go) state_next = BUSY;
      BUSY:    if (dmem_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- request register: held stable for the whole BUSY period ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
    end else if ((state == IDLE) && mem_go) begin
      dmem_req_o   <= 1'b1;
      dmem_we_o    <= is_store;
      dmem_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
      dmem_be_o    <= be_c;
      dmem_wdata_o <= wdata_c;
    end else if (ack_done) begin
      dmem_req_o   <= 1'b0;
    end
  end

  // ---- writeback register: bubble unless an op completes this edge ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      instr_o      <= '0;
      alu_result_o <= '0;
      mem_data_o   <= '0;
      rd_addr_o    <= '0;
      reg_write_o  <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o   <= 1'b0;
`endif
    end else if (wb_load) begin
      valid_o      <= 1'b1;
      instr_o      <= instr_i;
      alu_result_o <= alu_result_i;
      mem_data_o   <= (ack_done && is_load) ? load_c : '0;
      rd_addr_o    <= rd_addr_i;
      reg_write_o  <= reg_write_i && !misalign;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o   <= misalign;
`endif
    end else begin
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o   <= 1'b0;
`endif
    end
  end

endmodule
